// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and SRAM port of the unified-memory arbiter.
// Handshake: a requester raises ireq/dreq with stable qualifiers and holds them until it
// samples irdy/drdy high at a rising edge; each rdy is a one-cycle pulse in the cycle after the grant.
interface mem_arbiter_if #(
    parameter int AW = 12
);
    logic          ireq;
    logic [31:0]   iaddr;
    logic [31:0]   instr;
    logic          irdy;
    logic          dreq;
    logic [31:0]   daddr;
    logic          drw;
    logic [1:0]    dsize;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic          drdy;
    logic          derr;
    logic          mcsn;
    logic [AW-1:0] maddr;
    logic          mwe;
    logic [3:0]    mbe;
    logic [31:0]   mdi;
    logic [31:0]   mdo;

    // slave: the arbiter itself; master: requesters plus the SRAM
    modport slave (
        input  ireq, iaddr, dreq, daddr, drw, dsize, din, mdo,
        output instr, irdy, dout, drdy, derr, mcsn, maddr, mwe, mbe, mdi
    );

    modport master (
        output ireq, iaddr, dreq, daddr, drw, dsize, din, mdo,
        input  instr, irdy, dout, drdy, derr, mcsn, maddr, mwe, mbe, mdi
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the fetch and data ports onto one synchronous single-port SRAM.
// Define ARB_STARVE_GUARD_EN to let a fetch win after STARVE_LIM consecutive lost arbitrations.
module mem_arbiter #(
    parameter int AW         = 12,
    parameter int STARVE_LIM = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    logic       resp_i;
    logic       resp_d;
    logic       derr_q;
    logic       i_elig;
    logic       d_elig;
    logic       grant_i;
    logic       grant_d;
    logic       fetch_first;
    logic       d_ok;
    logic [3:0] d_be;

    // A port whose response is due this cycle still holds REQ, so it must not be re-granted.
    assign i_elig = bus.ireq & ~resp_i & ~reset;
    assign d_elig = bus.dreq & ~resp_d & ~reset;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign fetch_first = (starve_cnt == 3'(STARVE_LIM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else if (!bus.ireq || grant_i) begin
            starve_cnt <= 3'd0;
        end else if (i_elig && grant_d && (starve_cnt != 3'(STARVE_LIM))) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    logic [2:0] unused_starve_lim;

    assign unused_starve_lim = 3'(STARVE_LIM);
    assign fetch_first       = 1'b0;
`endif

    assign grant_d = d_elig & ~(i_elig & fetch_first);
    assign grant_i = i_elig & ~grant_d;

    // Lane enables; anything not naturally aligned is an error with no lanes enabled.
    always_comb begin
        d_be = 4'b0000;
        d_ok = 1'b0;
        case (bus.dsize)
            2'b00: begin
                d_be = 4'b0001 << bus.daddr[1:0];
                d_ok = 1'b1;
            end
            2'b01: begin
                if (bus.daddr[1:0] == 2'b00) begin
                    d_be = 4'b0011;
                    d_ok = 1'b1;
                end else if (bus.daddr[1:0] == 2'b10) begin
                    d_be = 4'b1100;
                    d_ok = 1'b1;
                end
            end
            2'b10: begin
                if (bus.daddr[1:0] == 2'b00) begin
                    d_be = 4'b1111;
                    d_ok = 1'b1;
                end
            end
            default: begin
                d_be = 4'b0000;
                d_ok = 1'b0;
            end
        endcase
    end

    assign bus.mcsn  = ~(grant_i | grant_d);
    assign bus.maddr = grant_d ? bus.daddr[AW+1:2] : (grant_i ? bus.iaddr[AW+1:2] : '0);
    assign bus.mwe   = grant_d & bus.drw & d_ok;
    assign bus.mbe   = grant_d ? d_be : (grant_i ? 4'b1111 : 4'b0000);
    assign bus.mdi   = bus.din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_i <= 1'b0;
            resp_d <= 1'b0;
            derr_q <= 1'b0;
        end else begin
            resp_i <= grant_i;
            resp_d <= grant_d;
            derr_q <= grant_d & ~d_ok;
        end
    end

    // Read data flows straight from the SRAM; only the response flags are registered.
    assign bus.irdy  = resp_i;
    assign bus.instr = bus.mdo;
    assign bus.drdy  = resp_d;
    assign bus.dout  = bus.mdo;
    assign bus.derr  = resp_d & derr_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.iaddr[31:AW+2], bus.iaddr[1:0], bus.daddr[31:AW+2]};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cases and randomized two-port traffic against a transaction-level
// model of the arbiter that keeps its own shadow copy of the memory contents.
module tb_mem_arbiter;
    localparam int AW         = 12;
    localparam int STARVE_LIM = 4;
    localparam int DEPTH      = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(.AW(AW), .STARVE_LIM(STARVE_LIM)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // SRAM: samples address at the rising edge, read data valid the following cycle.
    logic [31:0] sram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (bus.mcsn === 1'b0) begin
            bus.mdo <= sram[bus.maddr];
            if (bus.mwe === 1'b1) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mbe[b]) sram[bus.maddr][8*b +: 8] = bus.mdi[8*b +: 8];
                end
            end
        end
    end

    // Scoreboard: responses owed next cycle, recorded at grant time from the shadow memory.
    logic [31:0] exp_i_q [$];
    logic [33:0] exp_d_q [$];  // {error, write, read data}
    int lost       = 0;
    int fetch_wait = 0;

    always @(negedge clk) begin : model
        logic        ans_i, ans_d, f_wants, d_wants, f_wins, d_wins, legal, guard_fire;
        logic [33:0] rec;
        logic [3:0]  mask;
        int          nbytes, off, w;
        if (reset) begin
            exp_i_q.delete();
            exp_d_q.delete();
            lost       = 0;
            fetch_wait = 0;
            chk("rst_mcsn", 32'(bus.mcsn), 32'd1);
            chk("rst_mwe", 32'(bus.mwe), 32'd0);
            chk("rst_mbe", 32'(bus.mbe), 32'd0);
            chk("rst_maddr", 32'(bus.maddr), 32'd0);
            chk("rst_irdy", 32'(bus.irdy), 32'd0);
            chk("rst_drdy", 32'(bus.drdy), 32'd0);
            chk("rst_derr", 32'(bus.derr), 32'd0);
        end else begin
            ans_i = (exp_i_q.size() != 0);
            ans_d = (exp_d_q.size() != 0);
            chk("irdy", 32'(bus.irdy), 32'(ans_i));
            if (ans_i) chk("instr", bus.instr, exp_i_q.pop_front());
            chk("drdy", 32'(bus.drdy), 32'(ans_d));
            if (ans_d) begin
                rec = exp_d_q.pop_front();
                chk("derr", 32'(bus.derr), 32'(rec[33]));
                if (!rec[33] && !rec[32]) chk("dout", bus.dout, rec[31:0]);
            end else begin
                chk("derr_idle", 32'(bus.derr), 32'd0);
            end

`ifdef ARB_STARVE_GUARD_EN
            guard_fire = (lost == STARVE_LIM);
`else
            guard_fire = 1'b0;
`endif
            f_wants = bus.ireq && !ans_i;
            d_wants = bus.dreq && !ans_d;
            f_wins  = f_wants && (!d_wants || guard_fire);
            d_wins  = d_wants && !f_wins;

            // An access of 2^dsize bytes is legal only when the address is a multiple of its size.
            nbytes = 1 << bus.dsize;
            off    = int'(bus.daddr[1:0]);
            legal  = (bus.dsize != 2'b11) && ((off % nbytes) == 0);
            mask   = legal ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;

            if (f_wins) begin
                w = int'((bus.iaddr >> 2) % DEPTH);
                chk("g_mcsn", 32'(bus.mcsn), 32'd0);
                chk("g_maddr_i", 32'(bus.maddr), 32'(w));
                chk("g_mwe_i", 32'(bus.mwe), 32'd0);
                chk("g_mbe_i", 32'(bus.mbe), 32'hF);
                exp_i_q.push_back(ref_mem[w]);
            end else if (d_wins) begin
                w = int'((bus.daddr >> 2) % DEPTH);
                chk("g_mcsn", 32'(bus.mcsn), 32'd0);
                chk("g_maddr_d", 32'(bus.maddr), 32'(w));
                chk("g_mwe_d", 32'(bus.mwe), 32'(bus.drw && legal));
                chk("g_mbe_d", 32'(bus.mbe), 32'(mask));
                exp_d_q.push_back({!legal, bus.drw, ref_mem[w]});
                if (legal && bus.drw) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mask[b]) ref_mem[w][8*b +: 8] = bus.din[8*b +: 8];
                    end
                end
            end else begin
                chk("idle_mcsn", 32'(bus.mcsn), 32'd1);
                chk("idle_mwe", 32'(bus.mwe), 32'd0);
            end
            chk("mdi", bus.mdi, bus.din);

`ifdef ARB_STARVE_GUARD_EN
            if (f_wins) chk("starve_bound", 32'(fetch_wait <= STARVE_LIM), 32'd1);
`endif
            if (!bus.ireq || f_wins) lost = 0;
            else if (f_wants && d_wins && lost < STARVE_LIM) lost++;
            if (!bus.ireq || f_wins) fetch_wait = 0;
            else if (f_wants) fetch_wait++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_req(input logic [31:0] a);
        bus.ireq  = 1'b1;
        bus.iaddr = a;
    endtask

    task automatic data_req(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d);
        bus.dreq  = 1'b1;
        bus.drw   = rw;
        bus.dsize = sz;
        bus.daddr = a;
        bus.din   = d;
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        sram[w]    = v;
        ref_mem[w] = v;
    endtask

    task automatic rand_fetch();
        fetch_req(($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2));
    endtask

    task automatic rand_data();
        logic [1:0] sz;
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        data_req(1'($urandom), sz, ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2),
                 $urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic gi, gd;
    int   n_i, n_d;

    initial begin
        bus.ireq  = 1'b0;
        bus.iaddr = 32'd0;
        bus.dreq  = 1'b0;
        bus.daddr = 32'd0;
        bus.drw   = 1'b0;
        bus.dsize = 2'b10;
        bus.din   = 32'd0;
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t0_reset_mcsn", 32'(bus.mcsn), 32'd1);
        chk("t0_reset_irdy", 32'(bus.irdy), 32'd0);
        chk("t0_reset_mbe", 32'(bus.mbe), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Fetch only
        preload(4, 32'hE3A0_1001);
        fetch_req(32'h0000_0010);
        @(negedge clk);
        chk("t1_maddr", 32'(bus.maddr), 32'd4);
        chk("t1_mcsn", 32'(bus.mcsn), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_irdy", 32'(bus.irdy), 32'd1);
        chk("t1_instr", bus.instr, 32'hE3A0_1001);
        chk("t1_no_regrant", 32'(bus.mcsn), 32'd1);
        tick();
        bus.ireq = 1'b0;
        tick();

        // Byte write to lane 3, then read the word back
        preload(32'h40, 32'h1122_3344);
        data_req(1'b1, 2'b00, 32'h0000_0103, 32'hAB00_0000);
        @(negedge clk);
        chk("t2_mbe", 32'(bus.mbe), 32'h8);
        chk("t2_mwe", 32'(bus.mwe), 32'd1);
        chk("t2_maddr", 32'(bus.maddr), 32'h40);
        tick();
        @(negedge clk);
        chk("t2_drdy", 32'(bus.drdy), 32'd1);
        tick();
        data_req(1'b0, 2'b10, 32'h0000_0100, 32'd0);
        tick();
        @(negedge clk);
        chk("t2_drdy_rd", 32'(bus.drdy), 32'd1);
        chk("t2_dout_b3", 32'(bus.dout[31:24]), 32'hAB);
        chk("t2_dout", bus.dout, 32'hAB22_3344);
        tick();
        bus.dreq = 1'b0;
        tick();

        // Both pending: data first, fetch next
        preload(8, 32'hCAFE_0008);
        preload(9, 32'hDA7A_0009);
        fetch_req(32'h0000_0020);
        data_req(1'b0, 2'b10, 32'h0000_0024, 32'd0);
        @(negedge clk);
        chk("t3_data_first", 32'(bus.maddr), 32'd9);
        tick();
        @(negedge clk);
        chk("t3_drdy", 32'(bus.drdy), 32'd1);
        chk("t3_dout", bus.dout, 32'hDA7A_0009);
        chk("t3_fetch_next", 32'(bus.maddr), 32'd8);
        tick();
        bus.dreq = 1'b0;
        @(negedge clk);
        chk("t3_irdy", 32'(bus.irdy), 32'd1);
        chk("t3_instr", bus.instr, 32'hCAFE_0008);
        chk("t3_drdy_low", 32'(bus.drdy), 32'd0);
        tick();
        bus.ireq = 1'b0;
        tick();

        // Misaligned half write leaves memory untouched
        preload(0, 32'h1234_5678);
        data_req(1'b1, 2'b01, 32'h0000_0001, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t4_mwe", 32'(bus.mwe), 32'd0);
        chk("t4_mbe", 32'(bus.mbe), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_drdy", 32'(bus.drdy), 32'd1);
        chk("t4_derr", 32'(bus.derr), 32'd1);
        tick();
        data_req(1'b0, 2'b10, 32'h0000_0000, 32'd0);
        tick();
        @(negedge clk);
        chk("t4_derr_rd", 32'(bus.derr), 32'd0);
        chk("t4_mem_kept", bus.dout, 32'h1234_5678);
        tick();
        bus.dreq = 1'b0;
        tick();

        // Reset between a read grant and its response
        preload(5, 32'h0BAD_F00D);
        fetch_req(32'h0000_0014);
        @(negedge clk);
        chk("t5_grant", 32'(bus.mcsn), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_no_irdy", 32'(bus.irdy), 32'd0);
        chk("t5_mcsn_rst", 32'(bus.mcsn), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_no_rdy_after", 32'(bus.irdy), 32'd0);
        chk("t5_regrant", 32'(bus.maddr), 32'd5);
        tick();
        @(negedge clk);
        chk("t5_irdy", 32'(bus.irdy), 32'd1);
        chk("t5_instr", bus.instr, 32'h0BAD_F00D);
        tick();
        bus.ireq = 1'b0;
        tick();

        // Fetch held while data re-issues as fast as it may: ports alternate every cycle
        n_i = 0;
        n_d = 0;
        fetch_req(32'h0000_0000);
        data_req(1'b0, 2'b10, 32'h0000_0004, 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            gi = bus.irdy;
            gd = bus.drdy;
            n_i += int'(gi);
            n_d += int'(gd);
            tick();
            if (gi) fetch_req(32'(c * 4 + 8));
            if (gd) data_req(1'b0, 2'b10, 32'(c * 4 + 128), 32'd0);
        end
        chk("t6_drdy_count", 32'(n_d), 32'd10);
        chk("t6_irdy_count", 32'(n_i), 32'd9);
        bus.ireq = 1'b0;
        bus.dreq = 1'b0;
        repeat (2) tick();

        // Random traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gi = bus.irdy;
            gd = bus.drdy;
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            if (!bus.ireq || gi) begin
                if ($urandom_range(0, 99) < 60) rand_fetch();
                else bus.ireq = 1'b0;
            end
            if (!bus.dreq || gd) begin
                if ($urandom_range(0, 99) < 70) rand_data();
                else bus.dreq = 1'b0;
            end
        end
        reset    = 1'b0;
        bus.ireq = 1'b0;
        bus.dreq = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
